// File: rtl/timer_pkg.sv
// Shared types, constants and BCD helpers for the multi-channel countdown/stopwatch timer.
package timer_pkg;

    localparam int SEC_W = 19;
    localparam logic [SEC_W-1:0] MAX_SEC = 19'd359999;

    typedef enum logic [1:0] {
        MODE_ONESHOT   = 2'd0,
        MODE_RELOAD    = 2'd1,
        MODE_STOPWATCH = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    // Per-channel command bus; at most one of rst/set/stop/play is ever set.
    typedef struct packed {
        logic             rst;
        logic             set;
        logic             set_ok;
        logic             stop;
        logic             play;
        mode_e            mode;
        logic [SEC_W-1:0] load_sec;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic bcd_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
               (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9) &&
               (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
    endfunction

    function automatic logic [SEC_W-1:0] bcd_to_sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return SEC_W'(h[7:4]) * 19'd36000 + SEC_W'(h[3:0]) * 19'd3600 +
               SEC_W'(m[7:4]) * 19'd600   + SEC_W'(m[3:0]) * 19'd60 +
               SEC_W'(s[7:4]) * 19'd10    + SEC_W'(s[3:0]);
    endfunction

    // Double-dabble for a field value 0..99.
    function automatic logic [7:0] bin7_to_bcd(input logic [6:0] bin);
        logic [14:0] sr;
        sr = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sr[10:7] >= 4'd5) sr[10:7] = sr[10:7] + 4'd3;
            else                  sr[10:7] = sr[10:7];
            if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
            else                   sr[14:11] = sr[14:11];
            sr = {sr[13:0], 1'b0};
        end
        return sr[14:7];
    endfunction

    function automatic logic [23:0] sec_to_bcd(input logic [SEC_W-1:0] sec);
        logic [SEC_W-1:0] hrs;
        logic [SEC_W-1:0] rem;
        logic [6:0]       hrs7;
        logic [6:0]       mins;
        logic [6:0]       secs;
        hrs  = sec / 19'd3600;
        rem  = sec - hrs * 19'd3600;
        hrs7 = (hrs > 19'd99) ? 7'd99 : hrs[6:0];
        mins = 7'(rem / 19'd60);
        secs = 7'(rem - SEC_W'(mins) * 19'd60);
        return {bin7_to_bcd(hrs7), bin7_to_bcd(mins), bin7_to_bcd(secs)};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: count/stored value, mode, prescaler, running and sticky expiry flags.
module timer_channel
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 5000000,
    parameter int DEFAULT_SEC = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd_i,
    output logic [SEC_W-1:0] count_o,
    output logic             ring_o,
    output logic             counting_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0] DEF_SEC   = SEC_W'(DEFAULT_SEC);

    cmd_t             cmd_s;
    logic [SEC_W-1:0] count_q, count_d;
    logic [SEC_W-1:0] stored_q, stored_d;
    mode_e            mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             counting_q, counting_d;
    logic             ring_q, ring_d;
    logic             tick_s;
    logic             expire_s;
    logic             play_ok_s;

    assign cmd_s  = cmd_t'(cmd_i);
    assign tick_s = counting_q && (presc_q == PRESC_MAX);

    // Next-state: tick/expiry first, then the (single) command overrides count and run state.
    always_comb begin
        count_d    = count_q;
        stored_d   = stored_q;
        mode_d     = mode_q;
        presc_d    = presc_q;
        counting_d = counting_q;
        expire_s   = 1'b0;

        if (counting_q) presc_d = tick_s ? '0 : presc_q + PW'(1);
        else            presc_d = presc_q;

        if (tick_s) begin
            case (mode_q)
                MODE_ONESHOT: begin
                    if (count_q <= 19'd1) begin
                        count_d    = '0;
                        expire_s   = 1'b1;
                        counting_d = 1'b0;
                    end else begin
                        count_d = count_q - 19'd1;
                    end
                end
                MODE_RELOAD: begin
                    if (count_q <= 19'd1) begin
                        expire_s = 1'b1;
                        if (stored_q == '0) begin
                            count_d    = '0;
                            counting_d = 1'b0;
                        end else begin
                            count_d = stored_q;
                        end
                    end else begin
                        count_d = count_q - 19'd1;
                    end
                end
                MODE_STOPWATCH: begin
                    if (count_q >= MAX_SEC - 19'd1) begin
                        count_d    = MAX_SEC;
                        expire_s   = 1'b1;
                        counting_d = 1'b0;
                    end else begin
                        count_d = count_q + 19'd1;
                    end
                end
                default: counting_d = 1'b0;
            endcase
        end else begin
            expire_s = 1'b0;
        end

        // A play at a terminal count (or coinciding with expiry) would restart nothing useful.
        play_ok_s = !expire_s &&
                    !((mode_q != MODE_STOPWATCH) && (count_d == '0)) &&
                    !((mode_q == MODE_STOPWATCH) && (count_d == MAX_SEC));

        if (cmd_s.rst) begin
            count_d    = stored_q;
            counting_d = 1'b0;
            presc_d    = '0;
        end else if (cmd_s.set) begin
            if (cmd_s.set_ok) begin
                count_d    = cmd_s.load_sec;
                stored_d   = cmd_s.load_sec;
                mode_d     = cmd_s.mode;
                counting_d = 1'b0;
                presc_d    = '0;
            end else begin
                mode_d = mode_q;
            end
        end else if (cmd_s.stop) begin
            counting_d = 1'b0;
        end else if (cmd_s.play) begin
            if (play_ok_s) begin
                presc_d    = '0;
                counting_d = 1'b1;
            end else begin
                counting_d = 1'b0;
            end
        end else begin
            mode_d = mode_q;
        end

        if (expire_s)                                    ring_d = 1'b1;
        else if (cmd_s.rst || (cmd_s.set && cmd_s.set_ok)) ring_d = 1'b0;
        else                                             ring_d = ring_q;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= DEF_SEC;
            stored_q   <= DEF_SEC;
            mode_q     <= MODE_ONESHOT;
            presc_q    <= '0;
            counting_q <= 1'b0;
            ring_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            stored_q   <= stored_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            counting_q <= counting_d;
            ring_q     <= ring_d;
        end
    end

    assign count_o    = count_q;
    assign ring_o     = ring_q;
    assign counting_o = counting_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Multi-channel timer top: command edge detection and decode, channel array, BCD display mux.
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int TICK_DIV    = 5000000,
    parameter int DEFAULT_SEC = 10,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              set,
    input  logic              reset,
    input  logic              play,
    input  logic              stop,
    input  logic [1:0]        mode_in,
    input  logic [7:0]        hour_bcd_in,
    input  logic [7:0]        minute_bcd_in,
    input  logic [7:0]        second_bcd_in,
    input  logic [CH_W-1:0]   disp_sel,
    output logic [7:0]        hour_out_bcd,
    output logic [7:0]        minute_out_bcd,
    output logic [7:0]        second_out_bcd,
    output logic [CH_NUM-1:0] ring,
    output logic [CH_NUM-1:0] counting,
    output logic              set_err
);

    logic [3:0]       raw_s;
    logic [3:0]       sync1_q, sync2_q;
    logic [1:0]       rdy_q;
    logic [3:0]       pulse_s;
    logic             rst_p_s, set_p_s, stop_p_s, play_p_s;
    logic             set_ok_s;
    logic [SEC_W-1:0] load_sec_s;
    logic             set_err_q;
    logic [SEC_W-1:0] count_s [CH_NUM];
    logic [SEC_W-1:0] disp_sec_s;
    logic [23:0]      disp_bcd_s;
    logic [23:0]      disp_q;

    assign raw_s = {reset, set, stop, play};

    // rdy_q keeps the detector blind until both stages hold post-reset samples.
    assign pulse_s  = sync1_q & ~sync2_q & {4{rdy_q[1]}};
    assign rst_p_s  = pulse_s[3];
    assign set_p_s  = pulse_s[2] & ~pulse_s[3];
    assign stop_p_s = pulse_s[1] & ~pulse_s[3] & ~pulse_s[2];
    assign play_p_s = pulse_s[0] & ~pulse_s[3] & ~pulse_s[2] & ~pulse_s[1];

    assign set_ok_s   = bcd_valid(hour_bcd_in, minute_bcd_in, second_bcd_in) &&
                        (mode_in != MODE_RSVD);
    assign load_sec_s = bcd_to_sec(hour_bcd_in, minute_bcd_in, second_bcd_in);

    // Command edge detector and set-reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            rdy_q     <= 2'b00;
            set_err_q <= 1'b0;
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            rdy_q     <= {rdy_q[0], 1'b1};
            set_err_q <= set_p_s & ~set_ok_s;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic hit_s;
        cmd_t cmd_s;

        assign hit_s = (ch_sel == CH_W'(g));

        // Route the decoded command to this channel only when it is selected.
        always_comb begin
            cmd_s.rst      = hit_s & rst_p_s;
            cmd_s.set      = hit_s & set_p_s;
            cmd_s.set_ok   = set_ok_s;
            cmd_s.stop     = hit_s & stop_p_s;
            cmd_s.play     = hit_s & play_p_s;
            cmd_s.mode     = mode_e'(mode_in);
            cmd_s.load_sec = load_sec_s;
        end

        timer_channel #(
            .TICK_DIV    (TICK_DIV),
            .DEFAULT_SEC (DEFAULT_SEC)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_i      (cmd_s),
            .count_o    (count_s[g]),
            .ring_o     (ring[g]),
            .counting_o (counting[g])
        );
    end

    // Display select; an out-of-range disp_sel matches nothing and shows zero.
    always_comb begin
        disp_sec_s = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            disp_sec_s = disp_sec_s | (count_s[i] & {SEC_W{disp_sel == CH_W'(i)}});
        end
    end

    assign disp_bcd_s = sec_to_bcd(disp_sec_s);

    // Registered BCD display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) disp_q <= 24'h000000;
        else        disp_q <= disp_bcd_s;
    end

    assign hour_out_bcd   = disp_q[23:16];
    assign minute_out_bcd = disp_q[15:8];
    assign second_out_bcd = disp_q[7:0];
    assign set_err        = set_err_q;

endmodule
